fetch_queue: RTL and testbench

Parametrised instruction front-end sitting between the memory controller and the decoder/dispatch stage. It fetches instructions ahead of dispatch into a circular instruction queue, predicts next PC (JAL always taken, conditional branches via a 2-bit-counter branch history table, JALR halts fetch until redirected) and accepts predictor training from the reorder buffer. It decouples fetch latency from dispatch stalls and replaces the fixed always-taken branch policy.

---
 rtl/fetch_queue_pkg.sv | 35 +++
 rtl/fetch_queue_bht.sv | 47 ++++
 rtl/fetch_queue.sv | 174 +++++++++++++++++
 tb/tb_fetch_queue.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared front-end definitions: RV32I control-flow opcodes, immediate extraction,
// predictor reset value, FSM state type and instruction-queue entry layout.
package fetch_queue_pkg;

  localparam logic [6:0] OpcJal    = 7'b1101111;
  localparam logic [6:0] OpcJalr   = 7'b1100111;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [1:0] BhtResetCnt = 2'b01;

  localparam int unsigned EntryWidth = 97;

  typedef enum logic [1:0] {
    StFetch,
    StPredict,
    StHalt,
    StRestart
  } fq_state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        predict;
    logic [31:0] next_pc;
  } iq_entry_t;

  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_queue_bht.sv
// Branch history table: 2-bit saturating counters with an asynchronous read port
// and one synchronous training port.
module fetch_queue_bht
  import fetch_queue_pkg::*;
#(
  parameter int unsigned BHT_BITS = 6
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                en_i,
  input  logic [BHT_BITS-1:0] rd_idx_i,
  output logic [1:0]          rd_cnt_o,
  input  logic                upd_en_i,
  input  logic [BHT_BITS-1:0] upd_idx_i,
  input  logic                upd_taken_i
);

  localparam int unsigned Entries = 1 << BHT_BITS;

  logic [1:0] cnt_q [Entries];
  logic [1:0] upd_cur;
  logic [1:0] upd_cnt;

  // Reads see the pre-update value when indices collide.
  assign rd_cnt_o = cnt_q[rd_idx_i];

  always_comb begin
    upd_cur = cnt_q[upd_idx_i];
    upd_cnt = upd_cur;
    if (upd_taken_i) begin
      if (upd_cur != 2'b11) upd_cnt = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_cnt = upd_cur - 2'b01;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(Entries); i++) begin
        cnt_q[i] <= BhtResetCnt;
      end
    end else if (en_i && upd_en_i) begin
      cnt_q[upd_idx_i] <= upd_cnt;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front-end: fetches ahead into a circular queue, predicts the
// next PC per instruction and halts on JALR until the ROB redirects.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned IQ_DEPTH = 4,
  parameter int unsigned BHT_BITS = 6,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        mc_en,
  output logic [31:0] mc_addr,
  input  logic        mc_rdy,
  input  logic [31:0] mc_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_predict,
  output logic [31:0] out_next_pc,
  input  logic        bp_update_en,
  input  logic [31:0] bp_update_pc,
  input  logic        bp_update_taken
);

  localparam int unsigned PtrW = $clog2(IQ_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fq_state_e             state_q, state_d;
  logic [31:0]           pc_q, pc_d;
  logic [31:0]           inst_q, inst_d;
  logic [PtrW-1:0]       head_q, head_d;
  logic [PtrW-1:0]       tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [EntryWidth-1:0] iq_mem_q [IQ_DEPTH];

  iq_entry_t   head_entry;
  iq_entry_t   push_entry;
  logic [1:0]  bht_cnt;
  logic        is_jalr;
  logic        predict;
  logic [31:0] predict_pc;
  logic        full;
  logic        fetch_fire;
  logic        push;
  logic        pop;

  fetch_queue_bht #(
    .BHT_BITS(BHT_BITS)
  ) u_bht (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .en_i        (rdy_in),
    .rd_idx_i    (pc_q[BHT_BITS+1:2]),
    .rd_cnt_o    (bht_cnt),
    .upd_en_i    (bp_update_en),
    .upd_idx_i   (bp_update_pc[BHT_BITS+1:2]),
    .upd_taken_i (bp_update_taken)
  );

  // Next-PC prediction for the latched word, valid while in StPredict.
  always_comb begin
    is_jalr    = 1'b0;
    predict    = 1'b0;
    predict_pc = pc_q + 32'd4;
    case (inst_q[6:0])
      OpcJal: begin
        predict    = 1'b1;
        predict_pc = pc_q + imm_j(inst_q);
      end
      OpcBranch: begin
        predict = bht_cnt[1];
        if (bht_cnt[1]) predict_pc = pc_q + imm_b(inst_q);
      end
      OpcJalr: is_jalr = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    push_entry         = '0;
    push_entry.inst    = inst_q;
    push_entry.pc      = pc_q;
    push_entry.predict = predict;
    push_entry.next_pc = predict_pc;
  end

  assign head_entry  = iq_entry_t'(iq_mem_q[head_q]);
  assign out_valid   = (count_q != '0);
  assign out_inst    = head_entry.inst;
  assign out_pc      = head_entry.pc;
  assign out_predict = head_entry.predict;
  assign out_next_pc = head_entry.next_pc;

  assign full    = (count_q == CntW'(IQ_DEPTH));
  assign mc_en   = (state_q == StFetch) && !full;
  assign mc_addr = pc_q;

  // Flush discards everything in flight, so it masks fetch, push and pop.
  assign fetch_fire = rdy_in && !flush && mc_en && mc_rdy;
  assign push       = rdy_in && !flush && (state_q == StPredict);
  assign pop        = rdy_in && !flush && out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in && flush) begin
      state_d = StRestart;
      pc_d    = flush_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else if (rdy_in) begin
      unique case (state_q)
        StFetch: begin
          if (fetch_fire) begin
            inst_d  = mc_data;
            state_d = StPredict;
          end
        end
        StPredict: begin
          pc_d    = predict_pc;
          state_d = is_jalr ? StHalt : StFetch;
        end
        StHalt:    state_d = StHalt;
        StRestart: state_d = StFetch;
      endcase
      if (push) tail_d = tail_q + PtrW'(1);
      if (pop)  head_d = head_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= StFetch;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is cleared on reset so the head fields read zero before the first push.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < int'(IQ_DEPTH); i++) begin
        iq_mem_q[i] <= '0;
      end
    end else if (push) begin
      iq_mem_q[tail_q] <= push_entry;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bp_update_pc[31:BHT_BITS+2], bp_update_pc[1:0], bht_cnt[0]};

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized checks of fetch_queue against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned IQ_DEPTH = 4;
  localparam int unsigned BHT_BITS = 6;
  localparam logic [31:0] RESET_PC = 32'h0;

  localparam logic [31:0] InsAddi = 32'h0000_0013;
  localparam logic [31:0] InsJal  = 32'h0100_006F;
  localparam logic [31:0] InsBeq  = 32'hFE00_0CE3;
  localparam logic [31:0] InsJalr = 32'h0000_8067;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush, mc_rdy, out_ready;
  logic        bp_update_en, bp_update_taken;
  logic [31:0] flush_pc, mc_data, bp_update_pc;
  logic        mc_en, out_valid, out_predict;
  logic [31:0] mc_addr, out_inst, out_pc, out_next_pc;

  fetch_queue #(
    .IQ_DEPTH(IQ_DEPTH),
    .BHT_BITS(BHT_BITS),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .mc_en           (mc_en),
    .mc_addr         (mc_addr),
    .mc_rdy          (mc_rdy),
    .mc_data         (mc_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_inst        (out_inst),
    .out_pc          (out_pc),
    .out_predict     (out_predict),
    .out_next_pc     (out_next_pc),
    .bp_update_en    (bp_update_en),
    .bp_update_pc    (bp_update_pc),
    .bp_update_taken (bp_update_taken)
  );

  always #5 clk_in = ~clk_in;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        pred;
    logic [31:0] nxt;
  } ent_t;

  ent_t        m_q[$];
  int          m_bht[64];
  logic [31:0] m_pc, m_word;
  bit          m_have, m_halt, m_bubble, m_known;
  bit          auto_mem;
  logic [31:0] prog [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (prog.exists(a)) return prog[a];
    return InsAddi;
  endfunction

  function automatic logic [31:0] jal_off(input logic [31:0] w);
    int v;
    v = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096;
    if (w[31]) v -= (1 << 20);
    return 32'(v);
  endfunction

  function automatic logic [31:0] br_off(input logic [31:0] w);
    int v;
    v = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048;
    if (w[31]) v -= 4096;
    return 32'(v);
  endfunction

  function automatic bit exp_mc_en();
    return !m_have && !m_halt && !m_bubble && (m_q.size() < int'(IQ_DEPTH));
  endfunction

  task automatic check_outputs();
    if (!m_known) return;
    chk("mc_en", mc_en, exp_mc_en());
    if (exp_mc_en()) chk("mc_addr", mc_addr, m_pc);
    chk("out_valid", out_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      chk("out_inst", out_inst, m_q[0].inst);
      chk("out_pc", out_pc, m_q[0].pc);
      chk("out_predict", out_predict, m_q[0].pred);
      chk("out_next_pc", out_next_pc, m_q[0].nxt);
    end
  endtask

  task automatic model_step();
    ent_t e;
    int   idx;
    bit   en_now;
    if (!rst_in) begin
      m_known = 1;
      m_q.delete();
      m_pc = RESET_PC;
      m_have = 0;
      m_halt = 0;
      m_bubble = 0;
      foreach (m_bht[i]) m_bht[i] = 1;
      return;
    end
    if (!m_known || !rdy_in) return;
    en_now = exp_mc_en();
    // Prediction is formed from the counter value before this cycle's training.
    if (m_have) begin
      e.inst = m_word;
      e.pc   = m_pc;
      e.pred = 1'b0;
      e.nxt  = m_pc + 32'd4;
      if (m_word[6:0] == 7'h6F) begin
        e.pred = 1'b1;
        e.nxt  = m_pc + jal_off(m_word);
      end else if (m_word[6:0] == 7'h63) begin
        e.pred = (m_bht[int'((m_pc >> 2) % 64)] >= 2);
        if (e.pred) e.nxt = m_pc + br_off(m_word);
      end
    end
    if (bp_update_en) begin
      idx = int'((bp_update_pc >> 2) % 64);
      if (bp_update_taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
      else                 m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
    end
    if (flush) begin
      m_q.delete();
      m_pc = flush_pc;
      m_have = 0;
      m_halt = 0;
      m_bubble = 1;
      return;
    end
    if (m_q.size() != 0 && out_ready) void'(m_q.pop_front());
    if (m_bubble) begin
      m_bubble = 0;
    end else if (m_have) begin
      m_q.push_back(e);
      if (m_word[6:0] == 7'h67) m_halt = 1;
      m_pc = e.nxt;
      m_have = 0;
    end else if (en_now && mc_rdy) begin
      m_have = 1;
      m_word = mc_data;
    end
  endtask

  task automatic tick();
    if (auto_mem) mc_data = mem_word(m_pc);
    @(negedge clk_in);
    check_outputs();
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic wait_head_pc(input logic [31:0] pc, input int budget, input string tag);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (out_valid === 1'b1 && out_pc === pc) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic wait_fetch(input logic [31:0] addr, input int budget, input string tag);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (mc_en === 1'b1 && mc_addr === addr) begin
        seen = 1;
        break;
      end
      tick();
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  task automatic do_flush(input logic [31:0] pc);
    flush = 1'b1;
    flush_pc = pc;
    tick();
    flush = 1'b0;
  endtask

  task automatic train(input bit taken, input int n);
    bp_update_en = 1'b1;
    bp_update_pc = 32'h40;
    bp_update_taken = taken;
    repeat (n) tick();
    bp_update_en = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    rst_in = 1'b0; rdy_in = 1'b1; flush = 1'b0; flush_pc = '0;
    mc_rdy = 1'b0; mc_data = '0; out_ready = 1'b0;
    bp_update_en = 1'b0; bp_update_pc = '0; bp_update_taken = 1'b0;
    auto_mem = 1;
    m_known = 0;
    prog[32'h0]  = InsAddi;
    prog[32'h4]  = InsAddi;
    prog[32'h8]  = InsJal;
    prog[32'h40] = InsBeq;
    @(posedge clk_in);
    #1;
    tick();
    tick();
    rst_in = 1'b1;

    chk("rst_mc_en", mc_en, 1);
    chk("rst_mc_addr", mc_addr, RESET_PC);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_predict", out_predict, 0);
    chk("rst_out_next_pc", out_next_pc, 0);

    // Sequential fetch, then JAL redirect.
    mc_rdy = 1'b1;
    wait_head_pc(32'h0, 10, "first_valid");
    chk("addi_predict", out_predict, 0);
    chk("addi_next_pc", out_next_pc, 32'h4);
    chk("second_mc_addr", mc_addr, 32'h4);
    wait_fetch(32'd24, 20, "jal_fetch_24");
    chk("jal_head_still_0", out_pc, 32'h0);
    out_ready = 1'b1;
    tick();
    tick();
    out_ready = 1'b0;
    chk("jal_pc", out_pc, 32'h8);
    chk("jal_predict", out_predict, 1);
    chk("jal_next_pc", out_next_pc, 32'd24);

    // Fill the queue, then free one slot.
    repeat (16) tick();
    chk("full_mc_en", mc_en, 0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after_pop_mc_en", mc_en, 1);
    out_ready = 1'b1;
    repeat (12) tick();

    // BHT training on the BEQ at 0x40.
    do_flush(32'h40);
    wait_head_pc(32'h40, 20, "beq_seen_a");
    chk("beq_nt_predict", out_predict, 0);
    chk("beq_nt_next", out_next_pc, 32'h44);
    train(1'b1, 2);
    do_flush(32'h40);
    wait_head_pc(32'h40, 20, "beq_seen_b");
    chk("beq_t_predict", out_predict, 1);
    chk("beq_t_next", out_next_pc, 32'h38);
    train(1'b0, 5);
    do_flush(32'h40);
    wait_head_pc(32'h40, 20, "beq_seen_c");
    chk("beq_sat_predict", out_predict, 0);
    chk("beq_sat_next", out_next_pc, 32'h44);

    // JALR halts until redirected.
    prog[32'h10] = InsJalr;
    do_flush(32'h10);
    repeat (20) tick();
    chk("jalr_halt_mc_en", mc_en, 0);
    do_flush(32'h200);
    chk("restart_mc_en", mc_en, 0);
    chk("restart_out_valid", out_valid, 0);
    tick();
    chk("redirect_mc_en", mc_en, 1);
    chk("redirect_mc_addr", mc_addr, 32'h200);

    // Flush coincident with returning data, then reset coincident with flush.
    out_ready = 1'b0;
    mc_rdy = 1'b1;
    do_flush(32'h300);
    mc_rdy = 1'b0;
    tick();
    tick();
    chk("flush_discard_valid", out_valid, 0);
    chk("flush_discard_addr", mc_addr, 32'h300);
    mc_rdy = 1'b1;
    rst_in = 1'b0;
    flush = 1'b1;
    flush_pc = 32'h400;
    tick();
    rst_in = 1'b1;
    flush = 1'b0;
    mc_rdy = 1'b0;
    chk("rst_wins_mc_en", mc_en, 1);
    chk("rst_wins_mc_addr", mc_addr, RESET_PC);
    chk("rst_wins_valid", out_valid, 0);

    // Global enable low freezes everything, including flush and training.
    rdy_in = 1'b0;
    mc_rdy = 1'b1;
    flush = 1'b1;
    flush_pc = 32'h500;
    repeat (5) tick();
    flush = 1'b0;
    rdy_in = 1'b1;
    chk("rdy_hold_addr", mc_addr, RESET_PC);
    chk("rdy_hold_valid", out_valid, 0);

    // Randomized traffic.
    auto_mem = 0;
    for (int n = 0; n < 3000; n++) begin
      w = $urandom;
      case ($urandom_range(0, 7))
        0, 1: w[6:0] = 7'h63;
        2:    w[6:0] = 7'h6F;
        3:    w[6:0] = 7'h67;
        4:    w[6:0] = 7'h13;
        default: ;
      endcase
      mc_data         = w;
      rst_in          = ($urandom % 200) != 0;
      rdy_in          = ($urandom % 8) != 0;
      flush           = ($urandom % 40) == 0;
      flush_pc        = ($urandom % 64) * 4;
      mc_rdy          = ($urandom % 3) != 0;
      out_ready       = ($urandom % 2) != 0;
      bp_update_en    = ($urandom % 3) == 0;
      bp_update_pc    = ($urandom % 128) * 4;
      bp_update_taken = ($urandom % 2) != 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
